// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the five-stage pipeline and its control unit.
// master = pipeline side (raises requests, consumes stall/flush),
// slave  = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              stallreq_from_id;
  logic              stallreq_from_ex;
  logic [31:0]       excepttype_i;
  logic [31:0]       cp0_epc_i;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic              timeout_o;

  modport master (
    output stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles_o, timeout_o
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall vector, exception/ERET flush sequencing,
// request-stall cycle counter and a sticky long-stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VEC       = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 16,
  parameter int          CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_TIMEOUT - 1);
  localparam logic [31:0]      ERET_CODE = 32'h0000_000e;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [5:0]        stall_c;
  logic              exc_take;   // exception accepted this cycle
  logic              req_stall;  // request-driven stall cycle
  logic              flush_q;
  logic [31:0]       new_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RUN_W-1:0]  run_q;
  logic              timeout_q;

  // Next state and the combinational stall decode (exception > EX > ID).
  always_comb begin
    state_nxt = state;
    stall_c   = 6'b000000;
    exc_take  = 1'b0;
    req_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.excepttype_i != 32'h0) begin
            stall_c   = 6'b111111;
            exc_take  = 1'b1;
            state_nxt = FLUSH;
          end else if (bus.stallreq_from_ex) begin
            stall_c   = 6'b001111;
            req_stall = 1'b1;
          end else if (bus.stallreq_from_id) begin
            stall_c   = 6'b000111;
            req_stall = 1'b1;
          end
        end
        FLUSH: state_nxt = IDLE;  // one-cycle flush; inputs ignored
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, flush pulse/target, stall counter and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'h0;
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= exc_take;
      if (exc_take)
        new_pc_q <= (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VEC;
      if (req_stall && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      // Run length only survives across back-to-back request stalls.
      if (req_stall) begin
        if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
        if (run_q == RUN_LAST) timeout_q <= 1'b1;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign bus.stall          = stall_c;
  assign bus.flush          = flush_q;
  assign bus.new_pc         = new_pc_q;
  assign bus.stall_cycles_o = cnt_q;
  assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, watchdog sequence and a
// randomized run compared against a rule-level reference model.
module tb_pipe_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(.EXC_VEC(32'h20), .STALL_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_flush = 0;
  logic [31:0] m_pc = 0;
  logic [31:0] m_cnt = 0;
  int          m_run = 0;
  bit          m_to = 0;
  logic [5:0]  got_stall;
  logic [5:0]  exp_stall;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall(input bit r, input bit id, input bit ex,
                                             input logic [31:0] exc);
    if (r || m_flush) return 6'd0;
    if (exc != 0) return 6'b111111;
    if (ex) return 6'b001111;
    if (id) return 6'b000111;
    return 6'd0;
  endfunction

  // One clock: apply inputs, sample stall mid-cycle, advance the model at the edge.
  task automatic cyc(input bit r, input bit id, input bit ex,
                     input logic [31:0] exc, input logic [31:0] epc);
    rst = r; bus.stallreq_from_id = id; bus.stallreq_from_ex = ex;
    bus.excepttype_i = exc; bus.cp0_epc_i = epc;
    #2;
    got_stall = bus.stall;
    exp_stall = model_stall(r, id, ex, exc);
    @(posedge clk);
    if (r) begin
      m_flush = 0; m_pc = 0; m_cnt = 0; m_run = 0; m_to = 0;
    end else if (m_flush) begin
      m_flush = 0; m_run = 0;
    end else if (exc != 0) begin
      m_flush = 1; m_run = 0;
      m_pc = (exc == 32'he) ? epc : 32'h20;
    end else if (id || ex) begin
      if (m_cnt != 32'hffff_ffff) m_cnt++;
      if (m_run < TO) m_run++;
      if (m_run == TO) m_to = 1;
    end else begin
      m_run = 0;
    end
    #1;
  endtask

  task automatic chk_model();
    chk("m_stall", got_stall, exp_stall);
    chk("m_flush", bus.flush, m_flush);
    chk("m_new_pc", bus.new_pc, m_pc);
    chk("m_cnt", bus.stall_cycles_o, m_cnt);
    chk("m_timeout", bus.timeout_o, m_to);
  endtask

  typedef struct {
    bit r; bit id; bit ex; logic [31:0] exc; logic [31:0] epc;
    logic [5:0] e_stall; bit e_flush; logic [31:0] e_pc; logic [31:0] e_cnt; bit e_to;
  } vec_t;

  vec_t vt[$];

  initial begin
    bus.stallreq_from_id = 0; bus.stallreq_from_ex = 0;
    bus.excepttype_i = 0; bus.cp0_epc_i = 0;
    @(posedge clk); #1;

    //        r id ex exc     epc      stall    fl pc       cnt to
    vt.push_back('{1,0,0,32'h0, 32'h0,    6'o00,  0, 32'h0,    0, 0});
    for (int i = 0; i < 5; i++)
      vt.push_back('{0,0,0,32'h0, 32'h0,  6'o00,  0, 32'h0,    0, 0});
    vt.push_back('{0,1,0,32'h0, 32'h0,    6'o07,  0, 32'h0,    1, 0});
    vt.push_back('{0,1,0,32'h0, 32'h0,    6'o07,  0, 32'h0,    2, 0});
    vt.push_back('{0,1,0,32'h0, 32'h0,    6'o07,  0, 32'h0,    3, 0});
    vt.push_back('{0,1,1,32'h0, 32'h0,    6'o17,  0, 32'h0,    4, 0});
    vt.push_back('{0,0,1,32'h8, 32'h0,    6'o77,  1, 32'h20,   4, 0});
    vt.push_back('{0,0,0,32'h0, 32'h0,    6'o00,  0, 32'h20,   4, 0});
    vt.push_back('{0,0,0,32'he, 32'h1234, 6'o77,  1, 32'h1234, 4, 0});
    vt.push_back('{0,1,1,32'he, 32'h5678, 6'o00,  0, 32'h1234, 4, 0});
    vt.push_back('{0,0,0,32'h0, 32'h0,    6'o00,  0, 32'h1234, 4, 0});
    vt.push_back('{0,0,0,32'h1, 32'h1234, 6'o77,  1, 32'h20,   4, 0});
    vt.push_back('{1,0,0,32'h0, 32'h0,    6'o00,  0, 32'h0,    0, 0});
    vt.push_back('{0,0,0,32'h0, 32'h0,    6'o00,  0, 32'h0,    0, 0});
    vt.push_back('{0,1,0,32'hc, 32'h9999, 6'o77,  1, 32'h20,   0, 0});
    vt.push_back('{0,0,0,32'h0, 32'h0,    6'o00,  0, 32'h20,   0, 0});

    foreach (vt[i]) begin
      cyc(vt[i].r, vt[i].id, vt[i].ex, vt[i].exc, vt[i].epc);
      chk($sformatf("v%0d_stall", i), got_stall, vt[i].e_stall);
      chk($sformatf("v%0d_flush", i), bus.flush, vt[i].e_flush);
      chk($sformatf("v%0d_new_pc", i), bus.new_pc, vt[i].e_pc);
      chk($sformatf("v%0d_cnt", i), bus.stall_cycles_o, vt[i].e_cnt);
      chk($sformatf("v%0d_to", i), bus.timeout_o, vt[i].e_to);
    end

    // Watchdog: 15 held, 1 released, 16 held -> trips on the 16th edge.
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) cyc(0, 0, 1, 0, 0);
    chk("wd_after15", bus.timeout_o, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("wd_release", bus.timeout_o, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk($sformatf("wd_run%0d", i), bus.timeout_o, (i == 16));
    end
    chk("wd_cnt", bus.stall_cycles_o, 32'd31);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("wd_sticky", bus.timeout_o, 1'b1);
    cyc(0, 1, 0, 32'hd, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wd_sticky_exc", bus.timeout_o, 1'b1);
    cyc(1, 0, 0, 0, 0);
    chk("wd_rst", bus.timeout_o, 1'b0);
    chk("wd_rst_cnt", bus.stall_cycles_o, 32'd0);

    // Exception interrupting a long run clears the run length.
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 32'ha, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 0);
    chk("wd_exc_clears", bus.timeout_o, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] exc;
      int sel;
      sel = $urandom_range(0, 15);
      case (sel)
        0: exc = 32'he;
        1: exc = 32'h1;
        2: exc = 32'h8;
        3: exc = $urandom() | 32'h1;
        default: exc = 32'h0;
      endcase
      cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), exc, $urandom());
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
